// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared word type, pipeline control encodings and redirect-controller enums.
package pc_redirect_ctrl_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] WORD;

    typedef enum logic {
        STALL_NO  = 1'b0,
        STALL_YES = 1'b1
    } stall_pipeline_sig;

    typedef enum logic {
        BRANCH_FROM_WB_OFF = 1'b0,
        BRANCH_FROM_WB_ON  = 1'b1
    } branch_from_wb;

    typedef enum logic {
        TAKE_BRANCH_OFF = 1'b0,
        TAKE_BRANCH_ON  = 1'b1
    } take_branch_ctrl_sig;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        ISSUE = 2'd2,
        FLUSH = 2'd3
    } pc_redirect_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_EX   = 2'd2
    } redirect_src_t;

    // Thumb targets carry the mode flag in bit 0; the PC itself is halfword aligned.
    function automatic WORD thumb_align(input WORD addr);
        return {addr[WORD_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer: arbitrates WB/EX redirects against stalls and drives
// the wrong-path flush window.
//
// state | meaning
// RUN   | no redirect in flight, fetch on correct path
// PEND  | redirect latched, waiting for hazard stall to clear
// ISSUE | one-cycle redirect strobe to the PC, stall forced low
// FLUSH | draining wrong-path instructions, counter runs on unstalled cycles
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  stall_pipeline_sig   hazard_stall_i,
    input  branch_from_wb       wb_redirect_i,
    input  WORD                 wb_target_i,
    input  take_branch_ctrl_sig ex_redirect_i,
    input  WORD                 ex_target_i,
    output stall_pipeline_sig   stall_pipeline_o,
    output branch_from_wb       branch_from_wb_o,
    output take_branch_ctrl_sig take_branch_o,
    output WORD                 pop_pc_value_o,
    output WORD                 branch_pc_value_o,
    output logic                flush_if_id_o,
    output logic                flush_id_ex_o,
    output logic                fetch_valid_o
);

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    pc_redirect_state_t state_q, state_d;
    redirect_src_t      src_q, src_d;
    WORD                wb_tgt_q, wb_tgt_d;
    WORD                ex_tgt_q, ex_tgt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               wb_req;
    logic               ex_req;
    logic               stall;
    logic               wb_preempt;
    pc_redirect_state_t enter_state;

    assign wb_req      = (wb_redirect_i == BRANCH_FROM_WB_ON);
    assign ex_req      = (ex_redirect_i == TAKE_BRANCH_ON);
    assign stall       = (hazard_stall_i == STALL_YES);
    // Only an older WB redirect may displace an EX redirect already in flight.
    assign wb_preempt  = wb_req && (src_q == SRC_EX);
    assign enter_state = stall ? PEND : ISSUE;

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        wb_tgt_d = wb_tgt_q;
        ex_tgt_d = ex_tgt_q;
        cnt_d    = cnt_q;

        case (state_q)
            RUN: begin
                if (wb_req) begin
                    src_d    = SRC_WB;
                    wb_tgt_d = thumb_align(wb_target_i);
                    state_d  = enter_state;
                end else if (ex_req) begin
                    src_d    = SRC_EX;
                    ex_tgt_d = thumb_align(ex_target_i);
                    state_d  = enter_state;
                end
            end
            PEND: begin
                if (wb_preempt) begin
                    src_d    = SRC_WB;
                    wb_tgt_d = thumb_align(wb_target_i);
                end
                if (!stall) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (wb_preempt) begin
                    src_d    = SRC_WB;
                    wb_tgt_d = thumb_align(wb_target_i);
                    state_d  = enter_state;
                end else if (FLUSH_CYCLES == 1) begin
                    src_d   = SRC_NONE;
                    state_d = RUN;
                end else begin
                    cnt_d   = FLUSH_RELOAD;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (wb_preempt) begin
                    src_d    = SRC_WB;
                    wb_tgt_d = thumb_align(wb_target_i);
                    state_d  = enter_state;
                end else if (!stall) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        src_d   = SRC_NONE;
                        state_d = RUN;
                    end
                end
            end
            default: begin
                src_d   = SRC_NONE;
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= RUN;
            src_q    <= SRC_NONE;
            wb_tgt_q <= '0;
            ex_tgt_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            wb_tgt_q <= wb_tgt_d;
            ex_tgt_q <= ex_tgt_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        stall_pipeline_o = hazard_stall_i;
        branch_from_wb_o = BRANCH_FROM_WB_OFF;
        take_branch_o    = TAKE_BRANCH_OFF;
        flush_if_id_o    = 1'b0;
        flush_id_ex_o    = 1'b0;
        fetch_valid_o    = !reset_i;

        if (!reset_i) begin
            case (state_q)
                ISSUE: begin
                    // The PC gives stall priority over redirects, so release it here.
                    stall_pipeline_o = STALL_NO;
                    if (src_q == SRC_WB) begin
                        branch_from_wb_o = BRANCH_FROM_WB_ON;
                    end
                    if (src_q == SRC_EX) begin
                        take_branch_o = TAKE_BRANCH_ON;
                    end
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    fetch_valid_o = 1'b0;
                end
                FLUSH: begin
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    fetch_valid_o = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign pop_pc_value_o    = wb_tgt_q;
    assign branch_pc_value_o = ex_tgt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: per-cycle vector table plus flush-stall
// and reset-in-PEND sequences.
module tb_pc_redirect_ctrl;
    import pc_redirect_ctrl_pkg::*;

    logic                clk_i = 1'b0;
    logic                reset_i;
    stall_pipeline_sig   hazard_stall_i;
    branch_from_wb       wb_redirect_i;
    WORD                 wb_target_i;
    take_branch_ctrl_sig ex_redirect_i;
    WORD                 ex_target_i;
    stall_pipeline_sig   stall_pipeline_o;
    branch_from_wb       branch_from_wb_o;
    take_branch_ctrl_sig take_branch_o;
    WORD                 pop_pc_value_o;
    WORD                 branch_pc_value_o;
    logic                flush_if_id_o;
    logic                flush_id_ex_o;
    logic                fetch_valid_o;

    int n_cmp = 0;
    int n_err = 0;

    pc_redirect_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .hazard_stall_i    (hazard_stall_i),
        .wb_redirect_i     (wb_redirect_i),
        .wb_target_i       (wb_target_i),
        .ex_redirect_i     (ex_redirect_i),
        .ex_target_i       (ex_target_i),
        .stall_pipeline_o  (stall_pipeline_o),
        .branch_from_wb_o  (branch_from_wb_o),
        .take_branch_o     (take_branch_o),
        .pop_pc_value_o    (pop_pc_value_o),
        .branch_pc_value_o (branch_pc_value_o),
        .flush_if_id_o     (flush_if_id_o),
        .flush_id_ex_o     (flush_id_ex_o),
        .fetch_valid_o     (fetch_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        st;
        logic        wb;
        logic [31:0] wt;
        logic        ex;
        logic [31:0] et;
        logic        so;
        logic        bw;
        logic        tb;
        logic [31:0] pop;
        logic [31:0] brv;
        logic        fl;
        logic        fv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic wb, input logic [31:0] wt,
                       input logic ex, input logic [31:0] et,
                       input logic so, input logic bw, input logic tb,
                       input logic [31:0] pop, input logic [31:0] brv,
                       input logic fl, input logic fv);
        vec_t v;
        v.st = st; v.wb = wb; v.wt = wt; v.ex = ex; v.et = et;
        v.so = so; v.bw = bw; v.tb = tb; v.pop = pop; v.brv = brv;
        v.fl = fl; v.fv = fv;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic wb, input logic [31:0] wt,
                         input logic ex, input logic [31:0] et);
        hazard_stall_i = stall_pipeline_sig'(st);
        wb_redirect_i  = branch_from_wb'(wb);
        wb_target_i    = wt;
        ex_redirect_i  = take_branch_ctrl_sig'(ex);
        ex_target_i    = et;
    endtask

    // Inputs change 1 time unit after the edge, outputs are sampled 4 units after.
    task automatic next_cycle(input logic st, input logic wb, input logic [31:0] wt,
                              input logic ex, input logic [31:0] et);
        @(posedge clk_i);
        #1;
        drive(st, wb, wt, ex, et);
        #3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_if;
        int cnt_ex;
        int strobes;
        int fv_low;

        reset_i = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // row layout: st wb wt ex et | so bw tb pop brv fl fv
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 32'h000, 32'h000, 0, 1);
        add(1, 0, 32'h0,     0, 32'h0,     1, 0, 0, 32'h000, 32'h000, 0, 1);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 32'h000, 32'h000, 0, 1);
        // EX redirect, no stall
        add(0, 0, 32'h0,     1, 32'h101,   0, 0, 0, 32'h000, 32'h000, 0, 1);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 1, 32'h000, 32'h100, 1, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 32'h000, 32'h100, 1, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 32'h000, 32'h100, 0, 1);
        // EX redirect under a 3-cycle stall, re-presented EX not re-latched
        add(1, 0, 32'h0,     1, 32'h555,   1, 0, 0, 32'h000, 32'h100, 0, 1);
        add(1, 0, 32'h0,     1, 32'h777,   1, 0, 0, 32'h000, 32'h554, 0, 1);
        add(1, 0, 32'h0,     1, 32'h777,   1, 0, 0, 32'h000, 32'h554, 0, 1);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 32'h000, 32'h554, 0, 1);
        add(1, 0, 32'h0,     0, 32'h0,     0, 0, 1, 32'h000, 32'h554, 1, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 32'h000, 32'h554, 1, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 32'h000, 32'h554, 0, 1);
        // same-cycle WB and EX: WB wins
        add(0, 1, 32'h200,   1, 32'h300,   0, 0, 0, 32'h000, 32'h554, 0, 1);
        add(0, 0, 32'h0,     0, 32'h0,     0, 1, 0, 32'h200, 32'h554, 1, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 32'h200, 32'h554, 1, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 32'h200, 32'h554, 0, 1);
        // WB pre-empts the FLUSH of an EX redirect
        add(0, 0, 32'h0,     1, 32'h600,   0, 0, 0, 32'h200, 32'h554, 0, 1);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 1, 32'h200, 32'h600, 1, 0);
        add(0, 1, 32'h401,   1, 32'h700,   0, 0, 0, 32'h200, 32'h600, 1, 0);
        add(0, 0, 32'h0,     1, 32'h800,   0, 1, 0, 32'h400, 32'h600, 1, 0);
        add(0, 1, 32'h900,   0, 32'h0,     0, 0, 0, 32'h400, 32'h600, 1, 0);
        add(0, 0, 32'h0,     0, 32'h0,     0, 0, 0, 32'h400, 32'h600, 0, 1);

        // reset behaviour
        next_cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rst.fv", 32'(fetch_valid_o), 32'd0);
        chk("rst.so_hi", 32'(stall_pipeline_o), 32'd1);
        chk("rst.tb", 32'(take_branch_o), 32'd0);
        chk("rst.bw", 32'(branch_from_wb_o), 32'd0);
        chk("rst.fl", 32'(flush_if_id_o | flush_id_ex_o), 32'd0);
        next_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rst.so_lo", 32'(stall_pipeline_o), 32'd0);
        chk("rst.pop", pop_pc_value_o, 32'h0);
        chk("rst.brv", branch_pc_value_o, 32'h0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(posedge clk_i);
            #1;
            drive(vecs[i].st, vecs[i].wb, vecs[i].wt, vecs[i].ex, vecs[i].et);
            #3;
            chk($sformatf("row%0d.so", i),  32'(stall_pipeline_o),  32'(vecs[i].so));
            chk($sformatf("row%0d.bw", i),  32'(branch_from_wb_o),  32'(vecs[i].bw));
            chk($sformatf("row%0d.tb", i),  32'(take_branch_o),     32'(vecs[i].tb));
            chk($sformatf("row%0d.pop", i), pop_pc_value_o,         vecs[i].pop);
            chk($sformatf("row%0d.brv", i), branch_pc_value_o,      vecs[i].brv);
            chk($sformatf("row%0d.fif", i), 32'(flush_if_id_o),     32'(vecs[i].fl));
            chk($sformatf("row%0d.fie", i), 32'(flush_id_ex_o),     32'(vecs[i].fl));
            chk($sformatf("row%0d.fv", i),  32'(fetch_valid_o),     32'(vecs[i].fv));
        end

        // Stall held 2 cycles inside FLUSH stretches the flush window from 2 to 4.
        next_cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h1001);
        cnt_if = 0;
        cnt_ex = 0;
        for (int c = 1; c <= 9; c++) begin
            next_cycle((c == 2 || c == 3), 1'b0, 32'h0, 1'b0, 32'h0);
            if (c == 1) chk("fstall.tb", 32'(take_branch_o), 32'd1);
            if (flush_if_id_o) cnt_if++;
            if (flush_id_ex_o) cnt_ex++;
        end
        chk("fstall.if_cycles", 32'(cnt_if), 32'd4);
        chk("fstall.ex_cycles", 32'(cnt_ex), 32'd4);
        chk("fstall.brv", branch_pc_value_o, 32'h1000);
        chk("fstall.fv_end", 32'(fetch_valid_o), 32'd1);

        // Reset while a redirect is pending must drop it.
        next_cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'hABC);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        chk("rpend.fv_in_reset", 32'(fetch_valid_o), 32'd0);
        chk("rpend.so_in_reset", 32'(stall_pipeline_o), 32'd1);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        strobes = 0;
        fv_low  = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) next_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            if (take_branch_o == TAKE_BRANCH_ON || branch_from_wb_o == BRANCH_FROM_WB_ON
                || flush_if_id_o || flush_id_ex_o) strobes++;
            if (!fetch_valid_o) fv_low++;
        end
        chk("rpend.strobes", 32'(strobes), 32'd0);
        chk("rpend.fv_low", 32'(fv_low), 32'd0);
        chk("rpend.brv", branch_pc_value_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
